// File: rtl/wide_add_sequencer.sv
// Wide add/subtract sequencer: steps one 16-bit ripple adder across WORDS slices,
// LSB slice first, with a registered inter-slice carry and a one-cycle Done pulse.
module wide_add_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  Clock_in,
    input  logic                  Reset_n_in,
    input  logic                  Start_in,
    input  logic                  Sub_in,
    input  logic                  Clear_in,
    input  logic [16*WORDS-1:0]   A_in,
    input  logic [16*WORDS-1:0]   B_in,
    output logic                  Busy_out,
    output logic                  Done_out,
    output logic [16*WORDS-1:0]   Sum_out,
    output logic                  Carry_out,
    output logic                  Overflow_out
);

    localparam int unsigned W     = 16 * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [WORDS-1:0][15:0]  a_q, a_d;
    logic [WORDS-1:0][15:0]  b_q, b_d;
    logic [WORDS-1:0][15:0]  work_q, work_d;
    logic [W-1:0]            sum_q, sum_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic [15:0]             add_sum;
    logic                    add_co;

    // Single shared slice adder, fed by the current slice index.
    Adder_16 u_adder (
        .a_i (a_q[idx_q]),
        .b_i (b_q[idx_q]),
        .c_i (carry_q),
        .s_o (add_sum),
        .c_o (add_co)
    );

    always_ff @(posedge Clock_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Clear beats Start; DONE always leaves after one cycle.
                state_d = S_IDLE;
                if (!Clear_in && Start_in) begin
                    a_d     = A_in;
                    b_d     = Sub_in ? ~B_in : B_in;
                    carry_d = Sub_in;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (Clear_in) begin
                    state_d = S_IDLE;
                end else begin
                    work_d[idx_q] = add_sum;
                    carry_d       = add_co;
                    idx_d         = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(WORDS - 1)) begin
                        state_d = S_DONE;
                        sum_d   = work_d;
                        cout_d  = add_co;
                        ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                                  (add_sum[15] != a_q[WORDS-1][15]);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy_out     = (state_q == S_RUN);
    assign Done_out     = (state_q == S_DONE);
    assign Sum_out      = sum_q;
    assign Carry_out    = cout_q;
    assign Overflow_out = ovf_q;

endmodule

// 16-bit ripple-carry adder slice.
module Adder_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [16:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 16; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[16];
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WORDS = 4): vector table plus
// hand-written sequences for re-start, back-to-back, clear and async reset.
module tb_wide_add_sequencer;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 64;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         clear;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .Clock_in     (clk),
        .Reset_n_in   (rst_n),
        .Start_in     (start),
        .Sub_in       (sub),
        .Clear_in     (clear),
        .A_in         (a),
        .B_in         (b),
        .Busy_out     (busy),
        .Done_out     (done),
        .Sum_out      (sum),
        .Carry_out    (carry),
        .Overflow_out (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    endtask

    // Present operands with Start for one edge; returns at t0 + 1ns.
    task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        a     = av;
        b     = bv;
        sub   = sv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for Done, checking the old result stays visible meanwhile.
    task automatic wait_done(input logic [W-1:0] hold, output int n);
        n = 0;
        while (!done && n < 20) begin
            if (sum !== hold) chk("sum_hold", sum, hold);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n;
    int dcount;
    logic [W-1:0] prev;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[7] = '{64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0};
        vecs[8] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                    64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        clear = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prev = '0;
        for (int i = 0; i < 9; i++) begin
            pulse_start(vecs[i].a, vecs[i].b, vecs[i].sub);
            chk("busy_t0", busy, 1);
            wait_done(prev, n);
            chk("latency", 64'(n), 64'(WORDS));
            chk("done", done, 1);
            chk("busy_done", busy, 0);
            chk("sum", sum, vecs[i].sum);
            chk("carry", carry, vecs[i].c);
            chk("ovf", ovf, vecs[i].v);
            @(posedge clk);
            #1;
            chk("done_pulse", done, 0);
            prev = vecs[i].sum;
        end

        // Start re-pulsed in RUN is ignored: one Done only.
        pulse_start(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        a = 64'h0; b = 64'h0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(prev, n);
        chk("restart_lat", 64'(n), 64'(WORDS - 1));
        chk("restart_sum", sum, 64'h0000_0000_0001_0000);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("restart_single_done", 64'(dcount), 64'(0));
        chk("restart_idle", busy, 0);

        // Back-to-back: Start held during the Done cycle.
        pulse_start(64'h7, 64'h5, 1'b1);
        wait_done(64'h0000_0000_0001_0000, n);
        chk("b2b_first", sum, 64'h2);
        pulse_start(64'h1, 64'h2, 1'b0);
        chk("b2b_busy", busy, 1);
        chk("b2b_nodone", done, 0);
        wait_done(64'h2, n);
        chk("b2b_lat", 64'(n), 64'(WORDS));
        chk("b2b_done", done, 1);
        chk("b2b_sum", sum, 64'h3);
        @(posedge clk);
        #1;

        // Clear in RUN cycle 2: abort, no Done, outputs kept.
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_sum", sum, 64'h3);
        chk("clr_carry", carry, 0);
        dcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        chk("clr_no_done", 64'(dcount), 64'(0));
        chk("clr_sum_after", sum, 64'h3);

        // Clear and Start together in IDLE: Clear wins.
        a = 64'h1; b = 64'h1; sub = 1'b0; start = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; clear = 1'b0;
        chk("idle_clr_start", busy, 0);

        // Clear in DONE overrides Start.
        pulse_start(64'h10, 64'h20, 1'b0);
        wait_done(64'h3, n);
        chk("dclr_sum", sum, 64'h30);
        start = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; clear = 1'b0;
        chk("dclr_busy", busy, 0);
        chk("dclr_done", done, 0);

        // Asynchronous reset between edges mid-RUN.
        pulse_start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_carry", carry, 0);
        chk("arst_ovf", ovf, 0);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_stay_idle", busy, 0);
        chk("arst_sum_after", sum, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that runs one internally instantiated 16-bit ripple adder (Adder_16) over a WORDS-slice operand, least-significant slice first.
- Provides wide add/subtract to the calculator datapath without widening the adder.
- Latches operands on Start, steps one 16-bit slice per clock with a registered inter-slice carry, then publishes the result with a one-cycle Done pulse.

Parameters:
- WORDS, 4: number of 16-bit slices. Operand width W = 16*WORDS. Legal range is 2 to 16.

Ports:
- Clock_in  input  1  single clock; all state updates on the rising edge.
- Reset_n_in  input  1  asynchronous, active-low reset.
- Start_in  input  1  request a new operation; sampled only in IDLE or DONE.
- Sub_in  input  1  0 = A+B, 1 = A-B; sampled with Start_in.
- Clear_in  input  1  synchronous abort of a running operation.
- A_in  input  W  operand A; sampled with Start_in.
- B_in  input  W  operand B; sampled with Start_in.
- Busy_out  output  1  high while in RUN.
- Done_out  output  1  one-cycle completion pulse.
- Sum_out  output  W  result register.
- Carry_out  output  1  unsigned carry; for subtract, 1 = no borrow (A >= B unsigned).
- Overflow_out  output  1  two's-complement signed overflow of the W-bit result.

Behaviour:
- Reset (Reset_n_in low, at any time including mid-RUN):
  - state = IDLE; slice index, carry register and working registers = 0.
  - Busy_out = 0, Done_out = 0, Sum_out = 0, Carry_out = 0, Overflow_out = 0.
  - Effect is immediate, not waiting for a clock edge.
- States: IDLE, RUN, DONE.
- IDLE, Start_in = 1 at edge t0:
  - Latch A_in to A_reg.
  - Latch B_eff = Sub_in ? ~B_in : B_in.
  - Latch carry_reg = Sub_in and idx = 0.
  - Go to RUN.
- RUN, each edge:
  - Adder inputs are A_reg[16*idx +: 16], B_eff[16*idx +: 16] and carry_reg.
  - The adder's 16-bit sum is written into work_reg slice idx; its carry_out is written into carry_reg; idx increments.
  - Exactly one slice per cycle; the combinational adder settles within one cycle.
- RUN exit: on the edge that processes slice WORDS-1 (edge t0+WORDS):
  - Go to DONE.
  - Sum_out <= final work value.
  - Carry_out <= final carry.
  - Overflow_out <= (A_reg[W-1] == B_eff[W-1]) && (final sum[W-1] != A_reg[W-1]).
- Latency:
  - Busy_out is high during the WORDS cycles after t0.
  - Done_out is high for exactly the one cycle following edge t0+WORDS.
- DONE: returns to IDLE on the next edge. If Start_in = 1 on that edge, it is accepted exactly as in IDLE and goes straight to RUN, giving back-to-back operation with no idle cycle.
- Start_in in RUN is ignored; it is not queued.
- Output holding:
  - Sum_out, Carry_out and Overflow_out change only on RUN exit or reset.
  - They hold the previous result throughout a new RUN; partial slices are never visible.
- Clear_in = 1 in RUN: go to IDLE on that edge, with no Done pulse and outputs unchanged.
- Clear_in outside RUN has no effect, and in DONE it takes precedence over Start_in (go to IDLE, Start ignored).
- Clear_in and Start_in together in IDLE: Clear wins, Start ignored.
- Arithmetic is modulo 2^W. The carry chain wraps only through carry_reg, never from the top slice back to slice 0.

Test Plan (WORDS = 4, W = 64):
- Add, A=0x0000_0000_0000_FFFF, B=0x1, Start pulse at t0 -> Busy high 4 cycles; Done one cycle after t0+4; Sum=0x0000_0000_0001_0000, Carry=0, Ovf=0.
- Add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> Sum=0, Carry=1, Ovf=0. Also checks carry ripple through all 4 slices.
- Sub, A=5, B=7 -> Sum=0xFFFF_FFFF_FFFF_FFFE, Carry=0 (borrow), Ovf=0. Then Sub, A=7, B=5 -> Sum=2, Carry=1.
- Add, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=0x8000_0000_0000_0000, Ovf=1, Carry=0. Then Sub, A=0x8000_0000_0000_0000, B=1 -> Sum=0x7FFF_FFFF_FFFF_FFFF, Ovf=1.
- Start re-pulsed in RUN cycle 2 -> ignored, single Done. Start held during the Done cycle -> second op starts immediately and Done recurs 5 cycles later. Sum_out holds the first result until the second Done.
- Clear_in in RUN cycle 2 -> IDLE, no Done, Sum_out keeps old value. Reset_n_in low mid-RUN (asynchronous, between edges) -> all outputs 0 immediately, Busy 0.
